// File: rtl/tf_pkg.sv
// Shared types and constants for the twiddle-exponent scheduler.
// Tags are packed {stage, bfly}, so a +1 walks the whole run in order.
package tf_pkg;
    localparam int FFT_N          = 256;
    localparam int EXP_W          = 8;
    localparam int STAGE_W        = 2;
    localparam int BFLY_W         = 6;
    localparam int NUM_STAGES     = 4;
    localparam int BFLY_PER_STAGE = 64;
    localparam int ROM_LAT        = 1;

    localparam logic [BFLY_W-1:0] BFLY_MAX = BFLY_W'(BFLY_PER_STAGE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    typedef struct packed {
        logic [STAGE_W-1:0] stage;
        logic [BFLY_W-1:0]  bfly;
    } tag_t;

    // base = (j & (m-1)) << 2s with m = 64 >> 2s; (m-1) is simply 63 >> 2s
    function automatic logic [EXP_W-1:0] exp_base(input tag_t t);
        logic [BFLY_W-1:0] q;
        q = t.bfly & (BFLY_MAX >> {t.stage, 1'b0});
        return {2'b00, q} << {t.stage, 1'b0};
    endfunction
endpackage

// File: rtl/tf_exp_sched_if.sv
// Control/ROM-side bundle of the scheduler: run request, ROM exponents and TF handshake.
// master = scheduler, slave = the control FSM / TF consumer side.
interface tf_exp_sched_if;
    import tf_pkg::*;

    logic               start;
    logic [STAGE_W-1:0] cfg_first;
    logic [STAGE_W-1:0] cfg_last;
    logic [EXP_W-1:0]   exp0;
    logic [EXP_W-1:0]   exp1;
    logic [EXP_W-1:0]   exp2;
    logic [EXP_W-1:0]   exp3;
    logic               tf_valid;
    logic               tf_ready;
    logic [STAGE_W-1:0] tf_stage;
    logic [BFLY_W-1:0]  tf_bfly;
    logic               tf_last;
    logic               busy;
    logic               done;

    modport master (
        input  start, cfg_first, cfg_last, tf_ready,
        output exp0, exp1, exp2, exp3, tf_valid, tf_stage, tf_bfly, tf_last, busy, done
    );

    modport slave (
        output start, cfg_first, cfg_last, tf_ready,
        input  exp0, exp1, exp2, exp3, tf_valid, tf_stage, tf_bfly, tf_last, busy, done
    );
endinterface

// File: rtl/tf_exp_gen.sv
// Combinational exponent generator: (stage, bfly) -> four ROM lane exponents, mod 256.
// Zero latency, no state.
module tf_exp_gen
    import tf_pkg::*;
(
    input  tag_t             tag_i,
    output logic [EXP_W-1:0] exp0_o,
    output logic [EXP_W-1:0] exp1_o,
    output logic [EXP_W-1:0] exp2_o,
    output logic [EXP_W-1:0] exp3_o
);
    logic [EXP_W-1:0] base;
    logic [EXP_W-1:0] base2;

    assign base   = exp_base(tag_i);
    assign base2  = base << 1;
    assign exp0_o = '0;
    assign exp1_o = base;
    assign exp2_o = base2;
    assign exp3_o = base + base2;
endmodule

// File: rtl/tf_exp_sched.sv
// Walks (stage, bfly) and drives ROM exponents one cycle ahead of the TF words; 1 set/cycle.
// A stall (tf_ready low with tf_valid) freezes all state and re-presents the shown set's exponents.
module tf_exp_sched
    import tf_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    tf_exp_sched_if.master bus
);
    state_e             state_q, state_d;
    tag_t               p_q, p_d;
    tag_t               show_q, show_d;
    logic [STAGE_W-1:0] cfg_last_q, cfg_last_d;
    logic               tf_valid_q, tf_valid_d;
    logic               adv;
    logic               last_set;
    logic               gen_en;
    tag_t               gen_tag;
    logic [EXP_W-1:0]   e0, e1, e2, e3;

    assign adv      = !tf_valid_q || bus.tf_ready;
    assign last_set = tf_valid_q && ({show_q.stage, show_q.bfly} == {cfg_last_q, BFLY_MAX});

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        show_d     = show_q;
        cfg_last_d = cfg_last_q;
        tf_valid_d = tf_valid_q;
        if (adv) begin
            tf_valid_d = (state_q == RUN);
            show_d     = p_q;
        end
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    p_d        = '{stage: bus.cfg_first, bfly: '0};
                    cfg_last_d = (bus.cfg_first > bus.cfg_last) ? bus.cfg_first : bus.cfg_last;
                end
            end
            RUN: begin
                if (adv) begin
                    p_d = tag_t'(p_q + 1'b1);
                    if ({p_q.stage, p_q.bfly} == {cfg_last_q, BFLY_MAX}) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_set && bus.tf_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            p_q        <= '0;
            show_q     <= '0;
            cfg_last_q <= '0;
            tf_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            show_q     <= show_d;
            cfg_last_q <= cfg_last_d;
            tf_valid_q <= tf_valid_d;
        end
    end

    // The ROM address follows tf_ready combinationally so a stall re-reads the shown set.
    always_comb begin
        gen_tag = show_q;
        gen_en  = tf_valid_q;
        if (adv && (state_q == RUN)) begin
            gen_tag = p_q;
            gen_en  = 1'b1;
        end
    end

    tf_exp_gen u_exp_gen (
        .tag_i  (gen_tag),
        .exp0_o (e0),
        .exp1_o (e1),
        .exp2_o (e2),
        .exp3_o (e3)
    );

    assign bus.exp0     = gen_en ? e0 : '0;
    assign bus.exp1     = gen_en ? e1 : '0;
    assign bus.exp2     = gen_en ? e2 : '0;
    assign bus.exp3     = gen_en ? e3 : '0;
    assign bus.tf_valid = tf_valid_q;
    assign bus.tf_stage = show_q.stage;
    assign bus.tf_bfly  = show_q.bfly;
    assign bus.tf_last  = last_set;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
endmodule

// File: doc/tf_exp_sched.md
Name: tf_exp_sched

Overview:
Twiddle-exponent scheduler for the 256-point radix-4 DIF datapath. It walks (stage, butterfly) in order and drives the four 8-bit exponent inputs of the twiddle ROM block for each butterfly. It tracks the ROM block's 1-cycle read latency, so a TF_VALID/TF_READY handshake and a tag line up with the twiddle words. It sits between the FFT top-level control FSM and the twiddle ROM block.

Parameters:
NUM_STAGES, 4, radix-4 stages (log4 256); fixed, sizes stage fields
BFLY_PER_STAGE, 64, butterflies per stage (256/4); fixed, sizes butterfly field
ROM_LAT, 1, cycles from EXPx change to matching TFx; the pipeline model below is written for 1

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
START  in  1  one-cycle run request; sampled only in IDLE
CFG_FIRST  in  2  first stage to issue, latched on accepted START
CFG_LAST  in  2  last stage to issue, latched on accepted START
EXP0  out  8  exponent to ROM lane 0 (always 0 while issuing)
EXP1  out  8  exponent to ROM lane 1
EXP2  out  8  exponent to ROM lane 2
EXP3  out  8  exponent to ROM lane 3
TF_VALID  out  1  TF0..TF3 of the ROM block hold a valid butterfly set this cycle
TF_READY  in  1  consumer accepts the current set
TF_STAGE  out  2  stage tag of the set on TF
TF_BFLY  out  6  butterfly tag of the set on TF
TF_LAST  out  1  set on TF is the final one of the run
BUSY  out  1  high from accepted START until the DONE cycle, inclusive
DONE  out  1  one-cycle pulse after the last set is accepted

Behaviour:
- Reset (asynchronous, RST=1): state IDLE; TF_VALID=0, TF_STAGE=0, TF_BFLY=0, TF_LAST=0, BUSY=0, DONE=0; EXP0..3=0; issue pointer P=(0,0).
- At top level the ROM block's active-low reset is driven from ~RST.
- States:
  - IDLE: START=1 latches CFG, sets P=(CFG_FIRST,0), goes to RUN. If CFG_FIRST>CFG_LAST, latch CFG_LAST:=CFG_FIRST so exactly one stage runs.
  - RUN: issues sets. After the set (CFG_LAST,63) is issued, goes to DRAIN.
  - DRAIN: waits for TF_VALID&&TF_READY on the set with TF_LAST, then goes to DONE.
  - DONE: DONE=1 for one cycle, BUSY=1, then IDLE.
- START outside IDLE is ignored.
- Exponent math for set (s,j):
  - m = 64>>(2s); q = j & (m-1); base = q<<(2s), truncated to 8 bits.
  - EXP0=0, EXP1=base, EXP2=(2*base) mod 256, EXP3=(3*base) mod 256. All sums wrap to 8 bits.
  - Stage 3 always gives all zeros.
- Pipeline (ROM_LAT=1):
  - TF in cycle t reflects EXP in cycle t-1.
  - Internal SHOW register holds (s,j) of the set on TF; its tags drive TF_STAGE, TF_BFLY and TF_LAST.
  - adv = !TF_VALID || TF_READY.
  - EXP mux (combinational): if adv and state RUN, EXP = exps(P); else if TF_VALID, EXP = exps(SHOW), which re-presents the stalled set so TF stays stable; otherwise EXP = 0.
  - On the clock edge, if adv: TF_VALID <= (state==RUN); SHOW <= P; P advances j+1. j wraps 63->0 with s+1.
  - When adv=0 nothing updates.
- Combinational path TF_READY -> EXPx -> ROM address is intentional and must close timing. No other input->output combinational paths exist.
- Throughput is 1 set/cycle with TF_READY=1. Each stall cycle adds exactly one cycle.
- TF_READY is a don't-care while TF_VALID=0.
- Reset mid-run aborts immediately with no DONE pulse; the next START begins a fresh run.

Decomposition:
- Shared package tf_pkg:
  - constants FFT_N=256, EXP_W=8, STAGE_W=2, BFLY_W=6
  - state enum {IDLE, RUN, DRAIN, DONE}
  - a (stage, bfly) tag struct
- One combinational sub-module, tf_exp_gen (s, j -> EXP0..EXP3). It is instantiated once and fed by the P/SHOW mux output.

Test Plan:
- Reset then START with CFG=(0,3), TF_READY=1 held, START accepted at edge 0 -> EXP=(0,0,0,0) in cycle 1; TF_VALID=1 in cycles 2..257 (256 sets); TF_LAST only in cycle 257; DONE in cycle 258; BUSY in cycles 1..258.
- CFG=(1,1), observe set j=21 -> EXP=(0,20,40,60); set j=15 -> (0,60,120,180) (4*15=60, 2*60=120, 3*60=180).
- CFG=(0,0), set j=63 -> EXP=(0,63,126,189); CFG=(2,2), j=7 -> (0,48,96,144); any stage-3 set -> all zeros.
- Drop TF_READY for 3 cycles while TF shows (0,10) -> TF_BFLY stays 10 and EXP=(0,10,20,30) throughout the stall; after release, sets continue 11,12,... with no skip or duplicate; total run is 3 cycles longer.
- Pulse START while BUSY, and START with CFG=(3,1) -> the first is ignored; the second runs stage 3 only (64 sets), then DONE.
- Assert RST at set (1,30) -> all outputs 0 on the same cycle, state IDLE, no DONE; a new START runs cleanly from (CFG_FIRST,0).
